// File: rtl/fast_serial_pkg.sv
// Shared frame constants and FSM state types for the FT2232H fast serial PHY.
// Imported by fast_serial_fifo and fast_serial_phy.
package fast_serial_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    typedef enum logic {
        TX_IDLE,
        TX_SHIFT
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_SRC
    } rx_state_t;

endpackage

// File: rtl/fast_serial_fifo.sv
// First-word-fall-through byte FIFO for the RX path.
// A push into a full FIFO is accepted only when a pop frees a slot that cycle.
module fast_serial_fifo
    import fast_serial_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [DATA_BITS-1:0] push_data,
    input  logic                 pop,
    output logic [DATA_BITS-1:0] pop_data,
    output logic [AW:0]          count,
    output logic                 full,
    output logic                 empty
);

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign full     = count == (AW+1)'(DEPTH);
    assign empty    = count == '0;
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since empty masks the output.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap mod DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/fast_serial_phy.sv
// Bit-level FT2232H fast serial PHY: FSCLK generation, FSDI TX, FSDO RX.
// Define FAST_SERIAL_ERR_CNT_EN to add saturating overflow/source-error counters.
module fast_serial_phy
    import fast_serial_pkg::*;
#(
    parameter int   CLK_DIV       = 4,
    parameter int   RX_FIFO_DEPTH = 16,
    parameter logic SOURCE_BIT    = 1'b0
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    output logic                 fsclk,
    output logic                 fsdi,
    input  logic                 fsdo,
    input  logic                 fscts,
    output logic                 rx_stream_valid,
    output logic [DATA_BITS-1:0] rx_stream_data,
    input  logic                 rx_stream_ready,
    input  logic                 tx_stream_valid,
    input  logic [DATA_BITS-1:0] tx_stream_data,
    output logic                 tx_stream_ready,
    output logic                 rx_overflow
`ifdef FAST_SERIAL_ERR_CNT_EN
    ,
    output logic [7:0]           rx_ovf_count,
    output logic [7:0]           rx_src_err_count
`endif
);

    localparam int CNT_W = $clog2(RX_FIFO_DEPTH) + 1;
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [3:0] TX_LAST  = 4'(FRAME_BITS - 1);
    localparam logic [2:0] RX_LAST  = 3'(DATA_BITS - 1);

    logic [7:0]           div_cnt;
    logic                 run;
    logic                 tick;
    logic                 rise_tick;
    logic                 fall_tick;
    logic                 halt;
    logic [1:0]           fsdo_sync;
    logic [1:0]           cts_sync;
    logic                 fsdo_s;
    logic                 cts_q;
    tx_state_t            tx_state;
    logic [DATA_BITS-1:0] hold;
    logic                 hold_full;
    logic                 hold_next;
    logic                 accept;
    logic                 load;
    logic [DATA_BITS:0]   shifter;
    logic [3:0]           tx_cnt;
    rx_state_t            rx_state;
    logic [DATA_BITS-1:0] rx_shift;
    logic [2:0]           rx_cnt;
    logic                 rx_push;
    logic                 pop;
    logic                 ovf_evt;
    logic [CNT_W-1:0]     fifo_count;
    logic                 fifo_full;
    logic                 fifo_empty;

    assign fsdo_s = fsdo_sync[1];

    // Park FSCLK low only when nothing is in flight and the FIFO is nearly full;
    // a pending high phase still completes so the clock always parks low.
    assign halt = tx_state == TX_IDLE && !hold_full && rx_state == RX_IDLE
               && fifo_count > CNT_W'(RX_FIFO_DEPTH - 2);
    assign run       = !(halt && !fsclk);
    assign tick      = run && div_cnt == DIV_LAST;
    assign rise_tick = tick && !fsclk;
    assign fall_tick = tick && fsclk;

    assign accept    = tx_stream_valid && tx_stream_ready;
    assign load      = tx_state == TX_IDLE && fall_tick && hold_full && cts_q;
    assign hold_next = accept ? 1'b1 : (load ? 1'b0 : hold_full);

    assign rx_stream_valid = !fifo_empty;
    assign pop             = rx_stream_valid && rx_stream_ready;
    assign ovf_evt         = rx_push && fifo_full && !pop;

    // Two-flop synchronisers for the asynchronous FTDI inputs.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            fsdo_sync <= 2'b11;
            cts_sync  <= 2'b00;
        end else begin
            fsdo_sync <= {fsdo_sync[0], fsdo};
            cts_sync  <= {cts_sync[0], fscts};
        end
    end

    // FSCLK divider: toggle every CLK_DIV cycles while running.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            div_cnt <= '0;
            fsclk   <= 1'b0;
        end else if (run) begin
            if (div_cnt == DIV_LAST) begin
                div_cnt <= '0;
                fsclk   <= !fsclk;
            end else begin
                div_cnt <= div_cnt + 8'd1;
            end
        end
    end

    // TX holding register and frame shifter; FSDI changes on falling FSCLK.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            tx_state        <= TX_IDLE;
            fsdi            <= 1'b1;
            hold            <= '0;
            hold_full       <= 1'b0;
            shifter         <= '0;
            tx_cnt          <= '0;
            cts_q           <= 1'b0;
            tx_stream_ready <= 1'b0;
        end else begin
            hold_full       <= hold_next;
            tx_stream_ready <= !hold_next;
            if (rise_tick) begin
                cts_q <= cts_sync[1];
            end
            if (accept) begin
                hold <= tx_stream_data;
            end
            unique case (tx_state)
                TX_IDLE: begin
                    if (load) begin
                        fsdi     <= 1'b0;
                        shifter  <= {SOURCE_BIT, hold};
                        tx_cnt   <= '0;
                        tx_state <= TX_SHIFT;
                    end
                end
                TX_SHIFT: begin
                    if (fall_tick) begin
                        if (tx_cnt == TX_LAST) begin
                            fsdi     <= 1'b1;
                            tx_state <= TX_IDLE;
                        end else begin
                            fsdi    <= shifter[0];
                            shifter <= shifter >> 1;
                            tx_cnt  <= tx_cnt + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    // RX deframer: sample on rising FSCLK, push the byte one cycle after the source bit.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rx_state    <= RX_IDLE;
            rx_shift    <= '0;
            rx_cnt      <= '0;
            rx_push     <= 1'b0;
            rx_overflow <= 1'b0;
        end else begin
            rx_push     <= 1'b0;
            rx_overflow <= ovf_evt;
            if (rise_tick) begin
                unique case (rx_state)
                    RX_IDLE: begin
                        if (!fsdo_s) begin
                            rx_cnt   <= '0;
                            rx_state <= RX_DATA;
                        end
                    end
                    RX_DATA: begin
                        rx_shift <= {fsdo_s, rx_shift[DATA_BITS-1:1]};
                        rx_cnt   <= rx_cnt + 3'd1;
                        if (rx_cnt == RX_LAST) begin
                            rx_state <= RX_SRC;
                        end
                    end
                    RX_SRC: begin
                        rx_push  <= fsdo_s == SOURCE_BIT;
                        rx_state <= RX_IDLE;
                    end
                    default: rx_state <= RX_IDLE;
                endcase
            end
        end
    end

    fast_serial_fifo #(
        .DEPTH     (RX_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_clk),
        .rst       (reset_reset),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (pop),
        .pop_data  (rx_stream_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef FAST_SERIAL_ERR_CNT_EN
    logic src_err;

    assign src_err = rise_tick && rx_state == RX_SRC && fsdo_s != SOURCE_BIT;

    // Saturating error counters, cleared only by reset.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            rx_ovf_count     <= '0;
            rx_src_err_count <= '0;
        end else begin
            if (ovf_evt && rx_ovf_count != 8'hFF) begin
                rx_ovf_count <= rx_ovf_count + 8'd1;
            end
            if (src_err && rx_src_err_count != 8'hFF) begin
                rx_src_err_count <= rx_src_err_count + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fast_serial_phy.sv
// Randomised bench for fast_serial_phy with an FTDI bus-functional model
// and a queue-based reference of the byte streams.
module tb_fast_serial_phy;

    localparam int   CLK_DIV = 4;
    localparam int   DEPTH   = 16;
    localparam logic SRC     = 1'b0;
    localparam int   EDGE_LIM = 8 * CLK_DIV;
    localparam int   NRAND   = 10;

    logic       clk_clk = 1'b0;
    logic       reset_reset;
    logic       fsclk;
    logic       fsdi;
    logic       fsdo;
    logic       fscts;
    logic       rx_stream_valid;
    logic [7:0] rx_stream_data;
    logic       rx_stream_ready;
    logic       tx_stream_valid;
    logic [7:0] tx_stream_data;
    logic       tx_stream_ready;
    logic       rx_overflow;

    int         pass_cnt = 0;
    int         chk_cnt  = 0;
    bit         abort    = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         ovf_seen = 0;
    int         exp_ovf  = 0;
    logic [7:0] txd [NRAND];
    logic [7:0] rxd [NRAND];
    logic       rxs [NRAND];

    fast_serial_phy #(
        .CLK_DIV         (CLK_DIV),
        .RX_FIFO_DEPTH   (DEPTH),
        .SOURCE_BIT      (SRC)
    ) dut (
        .clk_clk         (clk_clk),
        .reset_reset     (reset_reset),
        .fsclk           (fsclk),
        .fsdi            (fsdi),
        .fsdo            (fsdo),
        .fscts           (fscts),
        .rx_stream_valid (rx_stream_valid),
        .rx_stream_data  (rx_stream_data),
        .rx_stream_ready (rx_stream_ready),
        .tx_stream_valid (tx_stream_valid),
        .tx_stream_data  (tx_stream_data),
        .tx_stream_ready (tx_stream_ready),
        .rx_overflow     (rx_overflow)
    );

    always #5 clk_clk = ~clk_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: run did not finish, %0d/%0d", pass_cnt, chk_cnt);
        $fatal(1, "watchdog");
    end

    // Consumer side: record every beat and overflow pulse.
    always @(negedge clk_clk) begin
        if (!reset_reset) begin
            if (rx_stream_valid && rx_stream_ready) got_q.push_back(rx_stream_data);
            if (rx_overflow) ovf_seen++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        chk_cnt++;
        if (obs == exp) pass_cnt++;
        else $display("FAIL %s: got 'h%0h expected 'h%0h", tag, obs, exp);
    endtask

    task automatic wait_edge(input logic lvl, output bit ok);
        logic prev;
        prev = fsclk;
        ok = 1'b0;
        for (int n = 0; n < EDGE_LIM; n++) begin
            @(negedge clk_clk);
            if (abort) return;
            if (prev != lvl && fsclk == lvl) begin
                ok = 1'b1;
                return;
            end
            prev = fsclk;
        end
        chk("fsclk_edge_timeout", 1, 0);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk_clk);
        #1 rx_stream_ready = v;
    endtask

    // FTDI side driving FSDO: one bit per falling FSCLK, then one idle bit.
    task automatic rx_send(input logic [7:0] d, input logic s);
        logic [9:0] f;
        bit ok;
        f = {s, d, 1'b0};
        for (int i = 0; i < 10; i++) begin
            wait_edge(1'b0, ok);
            if (!ok) return;
            fsdo = f[i];
        end
        wait_edge(1'b0, ok);
        if (!ok) return;
        fsdo = 1'b1;
    endtask

    // Reference: matching source bytes enter the FIFO unless 16 are pending.
    task automatic model_rx(input logic [7:0] d, input logic s);
        if (s != SRC) return;
        if (exp_q.size() - got_q.size() < DEPTH) exp_q.push_back(d);
        else exp_ovf++;
    endtask

    task automatic tx_offer(input logic [7:0] d);
        int n;
        n = 0;
        @(negedge clk_clk);
        tx_stream_valid = 1'b1;
        tx_stream_data  = d;
        while (!tx_stream_ready && n < 400 && !abort) begin
            @(negedge clk_clk);
            n++;
        end
        if (n >= 400) chk("tx_accept_timeout", 1, 0);
        @(negedge clk_clk);
        tx_stream_valid = 1'b0;
    endtask

    // FTDI side sampling FSDI on rising FSCLK; returns rises until start bit.
    task automatic tx_recv(input logic [7:0] d, output int rises);
        logic [9:0] f;
        bit ok;
        rises = 0;
        f = '1;
        do begin
            wait_edge(1'b1, ok);
            if (!ok) return;
            rises++;
        end while (fsdi != 1'b0 && rises < 40);
        f[0] = fsdi;
        for (int i = 1; i < 10; i++) begin
            wait_edge(1'b1, ok);
            if (!ok) return;
            f[i] = fsdi;
        end
        chk("tx_frame", int'(f), int'({SRC, d, 1'b0}));
        wait_edge(1'b1, ok);
        if (!ok) return;
        chk("tx_stop", int'(fsdi), 1);
    endtask

    task automatic compare_rx(input string tag);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < 400) begin
            @(negedge clk_clk);
            n++;
        end
        repeat (20) @(negedge clk_clk);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_data"}, int'(got_q[i]), int'(exp_q[i]));
        chk({tag, "_ovf"}, ovf_seen, exp_ovf);
        exp_q.delete();
        got_q.delete();
        ovf_seen = 0;
        exp_ovf  = 0;
    endtask

    initial begin
        int r;
        int low;
        int toggles;
        logic prev;
        bit ok;

        reset_reset     = 1'b1;
        fsdo            = 1'b1;
        fscts           = 1'b0;
        rx_stream_ready = 1'b0;
        tx_stream_valid = 1'b0;
        tx_stream_data  = '0;
        repeat (3) @(negedge clk_clk);
        chk("rst_fsclk", int'(fsclk), 0);
        chk("rst_fsdi", int'(fsdi), 1);
        chk("rst_valid", int'(rx_stream_valid), 0);
        chk("rst_data", int'(rx_stream_data), 0);
        chk("rst_ready", int'(tx_stream_ready), 0);
        chk("rst_ovf", int'(rx_overflow), 0);
        reset_reset = 1'b0;
        #1 chk("ready_before_edge", int'(tx_stream_ready), 0);
        @(negedge clk_clk);
        chk("ready_after_edge", int'(tx_stream_ready), 1);

        // Directed TX of 0xA5 with CTS asserted.
        fscts = 1'b1;
        repeat (4 * CLK_DIV) @(negedge clk_clk);
        fork
            tx_offer(8'hA5);
            tx_recv(8'hA5, r);
        join

        // CTS gate holds the frame until fscts rises.
        fscts = 1'b0;
        repeat (8 * CLK_DIV) @(negedge clk_clk);
        tx_offer(8'h3C);
        low = 0;
        repeat (6 * CLK_DIV) begin
            @(negedge clk_clk);
            if (!fsdi) low = 1;
        end
        chk("cts_hold_fsdi", low, 0);
        chk("cts_ready", int'(tx_stream_ready), 0);
        fscts = 1'b1;
        tx_recv(8'h3C, r);
        chk("cts_latency", int'(r <= 3), 1);

        // Directed RX: matching source delivered, other source discarded.
        set_ready(1'b1);
        rx_send(8'h5A, 1'b0);
        model_rx(8'h5A, 1'b0);
        rx_send(8'hC3, 1'b1);
        model_rx(8'hC3, 1'b1);
        compare_rx("rx_dir");

        // Random concurrent TX and RX traffic.
        for (int i = 0; i < NRAND; i++) begin
            txd[i] = 8'($urandom);
            rxd[i] = 8'($urandom);
            rxs[i] = ($urandom_range(3) == 0);
        end
        fork
            for (int i = 0; i < NRAND; i++) tx_offer(txd[i]);
            for (int i = 0; i < NRAND; i++) tx_recv(txd[i], r);
            for (int i = 0; i < NRAND; i++) begin
                rx_send(rxd[i], rxs[i]);
                model_rx(rxd[i], rxs[i]);
            end
        join
        compare_rx("rx_rand");

        // Fill the FIFO with the consumer stalled; clock parks when <2 free.
        set_ready(1'b0);
        for (int i = 0; i < DEPTH - 1; i++) begin
            rxd[0] = 8'($urandom);
            rx_send(rxd[0], SRC);
            model_rx(rxd[0], SRC);
        end
        toggles = 0;
        prev = fsclk;
        repeat (20 * CLK_DIV) begin
            @(negedge clk_clk);
            if (fsclk != prev) toggles++;
            prev = fsclk;
        end
        chk("halt_toggles", toggles, 0);
        chk("halt_level", int'(fsclk), 0);

        // Pending TX keeps the clock alive for bytes 16 and 17.
        for (int i = 0; i < 3; i++) txd[i] = 8'($urandom);
        fork
            for (int i = 0; i < 3; i++) tx_offer(txd[i]);
            for (int i = 0; i < 3; i++) tx_recv(txd[i], r);
            begin
                for (int i = 0; i < 2; i++) begin
                    rxd[i] = 8'($urandom);
                    rx_send(rxd[i], SRC);
                    model_rx(rxd[i], SRC);
                end
                chk("ovf_pulses", ovf_seen, 1);
                set_ready(1'b1);
            end
        join
        compare_rx("rx_ovf");

        // Reset in the middle of a TX and an RX frame.
        set_ready(1'b0);
        rx_send(8'h77, SRC);
        model_rx(8'h77, SRC);
        repeat (4) @(negedge clk_clk);
        chk("pre_rst_valid", int'(rx_stream_valid), 1);
        chk("pre_rst_data", int'(rx_stream_data), int'(exp_q[0]));
        fork
            tx_offer(8'h96);
            rx_send(8'h99, SRC);
            begin
                low = 0;
                for (int n = 0; n < 200 && low == 0; n++) begin
                    @(negedge clk_clk);
                    if (!fsdi) low = 1;
                end
                chk("rst_tx_started", low, 1);
                for (int i = 0; i < 4; i++) wait_edge(1'b0, ok);
                reset_reset = 1'b1;
                abort = 1'b1;
                #1;
                chk("midrst_fsdi", int'(fsdi), 1);
                chk("midrst_valid", int'(rx_stream_valid), 0);
                chk("midrst_fsclk", int'(fsclk), 0);
            end
        join
        fsdo = 1'b1;
        tx_stream_valid = 1'b0;
        repeat (5) @(negedge clk_clk);
        reset_reset = 1'b0;
        abort = 1'b0;
        exp_q.delete();
        got_q.delete();
        ovf_seen = 0;
        exp_ovf  = 0;
        low = 0;
        repeat (20 * CLK_DIV) begin
            @(negedge clk_clk);
            if (!fsdi) low = 1;
        end
        chk("no_resume", low, 0);
        chk("post_rst_valid", int'(rx_stream_valid), 0);

        // Clean frames after reset.
        set_ready(1'b1);
        txd[0] = 8'($urandom);
        rxd[0] = 8'($urandom);
        fork
            tx_offer(txd[0]);
            tx_recv(txd[0], r);
            begin
                rx_send(rxd[0], SRC);
                model_rx(rxd[0], SRC);
            end
        join
        compare_rx("rx_post");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
